// File: rtl/seq_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the {greater, lesser, equal} result codes.
package seq_comp_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

   // Result codes, packed as {greater, lesser, equal}.
   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_LT   = 3'b010;
   localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/comp_bit_cell.sv
// Single-bit compare cell. Reports which operand wins at this bit
// position; the sign bit of a two's-complement compare has its
// polarity inverted (a set sign bit means the smaller value).
module comp_bit_cell (
   input  logic a_bit,
   input  logic b_bit,
   input  logic is_sign,
   input  logic signed_mode,
   output logic gt,
   output logic lt
);

   logic mismatch;
   logic a_wins;

   // Decide the winner at this bit; no winner when the bits agree.
   always_comb begin
      mismatch = a_bit ^ b_bit;
      a_wins   = a_bit ^ (signed_mode & is_sign);
      gt       = mismatch & a_wins;
      lt       = mismatch & ~a_wins;
   end

endmodule

// File: rtl/seq_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Operands and mode are latched on an accepted start; results are held
// until the next accepted start, with a one-cycle done pulse.
// Build option: define SEQ_COMP_EARLY_EXIT_EN to leave the scan on the
// first mismatching bit instead of always scanning all WIDTH bits.
module seq_mag_comparator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             lesser,
   output logic             equal
);

   import seq_comp_pkg::*;

   state_e             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               mode_q;
   logic [CNT_W-1:0]   idx;
   logic               found;     // a mismatch has already decided the result
   logic               found_gt;  // decided result was A > B

   logic [WIDTH-1:0]   a_shift;
   logic [WIDTH-1:0]   b_shift;
   logic               is_sign;
   logic               last_bit;
   logic               cell_gt;
   logic               cell_lt;
   logic               finish;

   // Select the bit under test and decide whether this RUN cycle ends the scan.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      a_shift  = a_q >> idx;
      b_shift  = b_q >> idx;
      is_sign  = (idx == CNT_W'(WIDTH - 1));
      last_bit = (idx == '0);
`ifdef SEQ_COMP_EARLY_EXIT_EN
      finish   = last_bit | (~found & (cell_gt | cell_lt));
`else
      finish   = last_bit;
`endif
   end

   comp_bit_cell u_cell (
      .a_bit       (a_shift[0]),
      .b_bit       (b_shift[0]),
      .is_sign     (is_sign),
      .signed_mode (mode_q),
      .gt          (cell_gt),
      .lt          (cell_lt)
   );

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         greater  <= 1'b0;
         lesser   <= 1'b0;
         equal    <= 1'b0;
         // NOTE: the operand registers are plain flops, not a memory, so they
         // are cleared with everything else and never hold stale data after reset.
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         idx      <= '0;
         found    <= 1'b0;
         found_gt <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  mode_q   <= signed_mode;
                  idx      <= CNT_W'(WIDTH - 1);
                  greater  <= 1'b0;
                  lesser   <= 1'b0;
                  equal    <= 1'b0;
                  found    <= 1'b0;
                  found_gt <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end else begin
                  state    <= S_IDLE;
               end
            end
            S_RUN: begin
               if (finish) begin
                  state   <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  greater <= found ? found_gt  : cell_gt;
                  lesser  <= found ? ~found_gt : cell_lt;
                  equal   <= ~found & ~cell_gt & ~cell_lt;
               end else begin
                  idx <= idx - CNT_W'(1);
                  if (!found && (cell_gt || cell_lt)) begin
                     found    <= 1'b1;
                     found_gt <= cell_gt;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
